uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The module SHALL have parameter BAUDRATE, default `B115200 (104, from baudgen.vh), meaning clock cycles per serial bit; legal range 2..65535.
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-003 The module SHALL have port rstn, input, 1, reset, synchronous and active-low.
REQ-004 The module SHALL have port start, input, 1, transmit request, sampled only while ready=1.
REQ-005 The module SHALL have port data, input, 8, the byte to send, captured on the accepting edge.
REQ-006 The module SHALL have port ready, output, 1, registered; 1 = idle and able to accept a byte.
REQ-007 The module SHALL have port tx, output, 1, registered serial line; idle level 1.

Function
REQ-008 The frame format SHALL be 8N1: start bit (0), data[0] to data[7] LSB first, stop bit (1); 10 bits total.
REQ-009 The FSM SHALL have two states: IDLE (ready=1, tx=1) and TRANS (ready=0).
REQ-010 IDLE->TRANS SHALL occur on edge E where start=1 and ready=1; at E the design latches {1'b1, data, 1'b0} into a 10-bit shift register, clears the bit counter (4 bits) and the baud counter (16 bits).
REQ-011 After edge E, tx SHALL be 0 and ready SHALL be 0 (1-cycle latency from start sample to start bit).
REQ-012 Each bit SHALL be held on tx for exactly BAUDRATE clock cycles; the baud tick shifts the register right, fills with 1, and increments the bit counter.
REQ-013 TRANS->IDLE SHALL occur at edge E+10*BAUDRATE; from that edge ready=1 and tx=1.
REQ-014 start SHALL be ignored while ready=0; data changes after E SHALL NOT affect the frame in flight.
REQ-015 If start stays high, the next frame SHALL be accepted at edge E+10*BAUDRATE+1; minimum frame period is 10*BAUDRATE+1 cycles, with one idle-high cycle between frames.
REQ-016 The baud counter SHALL be cleared on frame accept so bit timing is phase-aligned to E, not free-running.
REQ-017 tx SHALL be glitch-free: driven directly from a flip-flop, never from combinational logic.

Reset
REQ-018 While rstn=0 at a rising edge, the design SHALL set state=IDLE, tx=1, ready=1, shift register all ones, and both counters 0.
REQ-019 Reset asserted mid-frame SHALL abort the frame; tx=1 and ready=1 after that edge, with no partial bits emitted afterwards.
REQ-020 start SHALL be ignored on any edge where rstn=0.

Structure
REQ-021 Baud divisor constants (`B115200, `B57600, `B38400, `B19200, `B9600, `B4800, `B2400, `B1200, `B600, `B300 for 12 MHz clk) SHALL live in the shared include baudgen.vh and not be redefined locally.
REQ-022 Bit timing SHALL be a sub-module baudgen_tx (clk, rstn, clk_ena in, clk_out tick out, parameter BAUDRATE); the tick is one cycle wide every BAUDRATE cycles while clk_ena=1, and the counter is held at 0 when clk_ena=0.
REQ-023 uart_tx SHALL contain only the FSM, shift register, bit counter and output registers; it drives clk_ena=1 only in TRANS.

Verification
REQ-024 Reset: rstn=0 for 2 cycles with start=1 -> tx=1, ready=1 throughout; no frame starts.
REQ-025 Send 0x55, BAUDRATE=104 -> tx = 0,1,0,1,0,1,0,1,0,1, each exactly 104 cycles; ready low for exactly 1040 cycles.
REQ-026 Send "K" (0x4B), then pulse start with data=0xFF at cycle 300 of the frame -> line decodes 0x4B only; no second frame.
REQ-027 Hold start=1, data=0x00 after a 0x4B frame -> second start bit begins exactly 1 cycle after ready rises; line decodes 0x4B then 0x00.
REQ-028 Send 0xA3, set data=0x00 one cycle after accept -> line decodes 0xA3.
REQ-029 Send 0x55, assert rstn=0 for 1 cycle during data bit 3 -> tx=1 and ready=1 the next cycle; a following 0x55 transmits with correct timing.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the 8N1 UART transmitter.
package uart_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int BITCNT_W   = 4;
    localparam int BAUDCNT_W  = 16;

    localparam logic [BITCNT_W-1:0]   LAST_BIT  = BITCNT_W'(FRAME_BITS - 1);
    localparam logic [FRAME_BITS-1:0] LINE_IDLE = '1;

    // Stop bit in the MSB, start bit in the LSB so the frame leaves LSB first.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] byte_in);
        return {1'b1, byte_in, 1'b0};
    endfunction

endpackage

// File: rtl/baudgen.vh
// Baud divisors in clock cycles per serial bit, for a 12 MHz system clock.
`ifndef BAUDGEN_VH
`define BAUDGEN_VH

`define B115200 104
`define B57600  208
`define B38400  313
`define B19200  625
`define B9600   1250
`define B4800   2500
`define B2400   5000
`define B1200   10000
`define B600    20000
`define B300    40000

`endif

// File: rtl/uart_tx_baudgen.sv
// Bit-period tick generator: one-cycle tick every BAUDRATE cycles while enabled.
`include "baudgen.vh"

module baudgen_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUDRATE = `B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam logic [BAUDCNT_W-1:0] CNT_MAX = BAUDCNT_W'(BAUDRATE - 1);

    logic [BAUDCNT_W-1:0] cnt_q;
    logic [BAUDCNT_W-1:0] cnt_d;

    // Holding the count at zero while disabled aligns every frame to its accept edge.
    always_comb begin
        cnt_d = '0;
        if (clk_ena) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_out = clk_ena && (cnt_q == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: FSM, frame shift register, bit counter and registered outputs.
`include "baudgen.vh"

module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUDRATE = `B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    state_t                state_q;
    state_t                state_d;
    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] shift_d;
    logic [BITCNT_W-1:0]   bitcnt_q;
    logic [BITCNT_W-1:0]   bitcnt_d;
    logic                  ready_q;
    logic                  ready_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  baud_ena;
    logic                  baud_tick;

    assign baud_ena = (state_q == TRANS);

    baudgen_tx #(
        .BAUDRATE(BAUDRATE)
    ) u_baudgen (
        .clk     (clk),
        .rstn    (rstn),
        .clk_ena (baud_ena),
        .clk_out (baud_tick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;

        case (state_q)
            IDLE: begin
                if (start && ready_q) begin
                    state_d  = TRANS;
                    shift_d  = make_frame(data);
                    bitcnt_d = '0;
                end
            end
            TRANS: begin
                if (baud_tick) begin
                    shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
                    if (bitcnt_q == LAST_BIT) begin
                        state_d  = IDLE;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                shift_d  = LINE_IDLE;
                bitcnt_d = '0;
            end
        endcase

        // Outputs are registered copies of the next state so tx never sees a combinational path.
        ready_d = (state_d == IDLE);
        tx_d    = shift_d[0];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            shift_q  <= LINE_IDLE;
            bitcnt_q <= '0;
            ready_q  <= 1'b1;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            ready_q  <= ready_d;
            tx_q     <= tx_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: line monitor decodes frames and checks them against queued bytes.
`timescale 1ns/1ps

module tb_uart_tx;

    localparam int BAUD      = 104;
    localparam int FRAME_CYC = 10 * BAUD;
    localparam int BUDGET    = 3000;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int frames_seen = 0;

    logic [7:0] exp_q[$];
    int         start_cyc_q[$];

    uart_tx #(
        .BAUDRATE(BAUD)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .data  (data),
        .ready (ready),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: samples every cycle, requires each bit constant for BAUD cycles.
    always begin : monitor
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic [7:0] exp_b;
        int         fcyc;
        @(negedge clk);
        if (rstn === 1'b1 && tx === 1'b0) begin
            aborted = 1'b0;
            fcyc    = cyc;
            bits    = '1;
            for (int b = 0; b < 10; b++) begin
                if (!aborted) begin
                    if (b != 0) begin
                        @(negedge clk);
                        if (rstn !== 1'b1) aborted = 1'b1;
                    end
                    bits[b] = tx;
                    stable  = 1'b1;
                    for (int s = 1; s < BAUD; s++) begin
                        if (!aborted) begin
                            @(negedge clk);
                            if (rstn !== 1'b1) aborted = 1'b1;
                            else if (tx !== bits[b]) stable = 1'b0;
                        end
                    end
                    if (!aborted) begin
                        checks++;
                        if (stable !== 1'b1) begin
                            errors++;
                            $display("FAIL bit_hold: bit %0d of frame at cycle %0d not constant, required %0d steady cycles", b, fcyc, BAUD);
                        end
                    end
                end
            end
            if (!aborted) begin
                frames_seen++;
                start_cyc_q.push_back(fcyc);
                checks++;
                if (bits[9] !== 1'b1) begin
                    errors++;
                    $display("FAIL stop_bit: got %b required 1 (frame at cycle %0d)", bits[9], fcyc);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got byte %02h required no frame", bits[8:1]);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bits[8:1] !== exp_b) begin
                        errors++;
                        $display("FAIL frame_data: got %02h required %02h", bits[8:1], exp_b);
                    end
                end
            end
        end
    end

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rstn  = 1'b0;
        start = 1'b1;
        data  = 8'h55;
        repeat (2) begin
            @(negedge clk);
            checks += 2;
            if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
            if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready); end
        end
        @(posedge clk); #2;
        rstn  = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b required 1", tx); end
        if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", ready); end
        if (frames_seen !== 0) begin errors++; $display("FAIL reset_no_frame: got %0d frames required 0", frames_seen); end
    endtask

    task automatic test_send_55();
        int n;
        int f0;
        f0 = frames_seen;
        @(posedge clk); #2;
        start = 1'b1;
        data  = 8'h55;
        exp_q.push_back(8'h55);
        @(posedge clk); #2;
        start = 1'b0;
        checks += 2;
        if (tx !== 1'b0) begin errors++; $display("FAIL accept_tx: got %b required 0", tx); end
        if (ready !== 1'b0) begin errors++; $display("FAIL accept_ready: got %b required 0", ready); end
        n = 0;
        @(negedge clk);
        while (ready === 1'b0 && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
        checks += 2;
        if (n !== FRAME_CYC) begin errors++; $display("FAIL ready_low: got %0d cycles required %0d", n, FRAME_CYC); end
        if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx: got %b required 1", tx); end
        repeat (5) @(negedge clk);
        checks++;
        if (frames_seen !== f0 + 1) begin errors++; $display("FAIL frame_count_55: got %0d required %0d", frames_seen, f0 + 1); end
    endtask

    task automatic test_ignore_start();
        int n;
        int f0;
        f0 = frames_seen;
        @(posedge clk); #2;
        start = 1'b1;
        data  = 8'h4B;
        exp_q.push_back(8'h4B);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (299) @(posedge clk);
        #2;
        start = 1'b1;
        data  = 8'hFF;
        @(posedge clk); #2;
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b required 0", ready); end
        wait_ready(n);
        checks++;
        if (n >= BUDGET) begin errors++; $display("FAIL ignore_timeout: ready not back after %0d cycles", n); end
        repeat (1200) @(negedge clk);
        checks += 3;
        if (frames_seen !== f0 + 1) begin errors++; $display("FAIL ignore_frames: got %0d required %0d", frames_seen, f0 + 1); end
        if (tx !== 1'b1) begin errors++; $display("FAIL ignore_tx: got %b required 1", tx); end
        if (ready !== 1'b1) begin errors++; $display("FAIL ignore_ready: got %b required 1", ready); end
    endtask

    task automatic test_back_to_back();
        int n;
        int f0;
        int rc;
        int s1;
        int s2;
        f0 = frames_seen;
        @(posedge clk); #2;
        start = 1'b1;
        data  = 8'h4B;
        exp_q.push_back(8'h4B);
        @(posedge clk); #2;
        data = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge clk);
        wait_ready(n);
        rc = cyc;
        checks++;
        if (n >= BUDGET) begin errors++; $display("FAIL b2b_timeout: ready not back after %0d cycles", n); end
        @(negedge clk);
        checks += 2;
        if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready: got %b required 0", ready); end
        if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start_bit: got %b required 0", tx); end
        @(posedge clk); #2;
        start = 1'b0;
        wait_ready(n);
        repeat (5) @(negedge clk);
        checks += 2;
        if (frames_seen !== f0 + 2) begin errors++; $display("FAIL b2b_frames: got %0d required %0d", frames_seen, f0 + 2); end
        if (start_cyc_q.size() < 2) begin
            errors++;
            $display("FAIL b2b_starts: got %0d recorded starts required at least 2", start_cyc_q.size());
        end else begin
            s2 = start_cyc_q[start_cyc_q.size() - 1];
            s1 = start_cyc_q[start_cyc_q.size() - 2];
            checks += 2;
            if (s2 - rc !== 1) begin errors++; $display("FAIL b2b_gap: got %0d cycles after ready required 1", s2 - rc); end
            if (s2 - s1 !== FRAME_CYC + 1) begin errors++; $display("FAIL b2b_period: got %0d required %0d", s2 - s1, FRAME_CYC + 1); end
        end
    endtask

    task automatic test_data_change();
        int n;
        int f0;
        f0 = frames_seen;
        @(posedge clk); #2;
        start = 1'b1;
        data  = 8'hA3;
        exp_q.push_back(8'hA3);
        @(posedge clk); #2;
        start = 1'b0;
        data  = 8'h00;
        @(negedge clk);
        wait_ready(n);
        repeat (5) @(negedge clk);
        checks += 2;
        if (n >= BUDGET) begin errors++; $display("FAIL a3_timeout: ready not back after %0d cycles", n); end
        if (frames_seen !== f0 + 1) begin errors++; $display("FAIL a3_frames: got %0d required %0d", frames_seen, f0 + 1); end
    endtask

    task automatic test_reset_mid_frame();
        int  n;
        int  f0;
        int  bad;
        logic [7:0] dropped;
        f0 = frames_seen;
        @(posedge clk); #2;
        start = 1'b1;
        data  = 8'h55;
        exp_q.push_back(8'h55);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (4 * BAUD + 50) @(posedge clk);
        #2;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL bit3_level: got %b required 0", tx); end
        rstn = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b required 1", tx); end
        if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", ready); end
        if (exp_q.size() !== 1) begin
            errors++;
            $display("FAIL abort_queue: got %0d pending required 1", exp_q.size());
        end else begin
            dropped = exp_q.pop_back();
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL abort_quiet: got %0d non-idle cycles required 0", bad); end

        @(posedge clk); #2;
        start = 1'b1;
        data  = 8'h55;
        exp_q.push_back(8'h55);
        @(posedge clk); #2;
        start = 1'b0;
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL resend_tx: got %b required 0", tx); end
        n = 0;
        @(negedge clk);
        while (ready === 1'b0 && n < BUDGET) begin
            n++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        checks += 2;
        if (n !== FRAME_CYC) begin errors++; $display("FAIL resend_ready_low: got %0d cycles required %0d", n, FRAME_CYC); end
        if (frames_seen !== f0 + 1) begin errors++; $display("FAIL resend_frames: got %0d required %0d", frames_seen, f0 + 1); end
    endtask

    initial begin
        test_reset();
        test_send_55();
        test_ignore_start();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL leftover: got %0d pending bytes required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
